// File: rtl/lpddr2_avl_tester.sv
// LPDDR2 Avalon-MM bring-up tester.
// After controller calibration, writes pattern(a) = {5'b0, a} ^ SEED over
// BASE_ADDR .. BASE_ADDR+NUM_WORDS-1, reads the range back with up to
// MAX_OUTSTANDING reads in flight, and reports pass, error count and the
// first failing word address.
module lpddr2_avl_tester #(
    parameter logic [26:0] BASE_ADDR       = 27'h0,
    parameter int unsigned NUM_WORDS       = 1024,
    parameter logic [31:0] SEED            = 32'hA5C3_0F96,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [26:0] first_err_addr,
    input  logic        lpddr2_status_local_init_done,
    input  logic        lpddr2_status_local_cal_success,
    input  logic        lpddr2_status_local_cal_fail,
    input  logic        lpddr2_avl_0_waitrequest_n,
    output logic        lpddr2_avl_0_beginbursttransfer,
    output logic [26:0] lpddr2_avl_0_address,
    input  logic        lpddr2_avl_0_readdatavalid,
    input  logic [31:0] lpddr2_avl_0_readdata,
    output logic [31:0] lpddr2_avl_0_writedata,
    output logic [3:0]  lpddr2_avl_0_byteenable,
    output logic        lpddr2_avl_0_read,
    output logic        lpddr2_avl_0_write,
    output logic        lpddr2_avl_0_burstcount
);

    // Word counters need one bit beyond the address so NUM_WORDS = 2^27 fits.
    localparam int CNT_W = 28;
    localparam logic [CNT_W-1:0] NUM_W    = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
    localparam logic [3:0]       MAX_OS   = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_idx_next;
    logic [CNT_W-1:0] wr_idx_inc;
    logic [3:0]       outstanding;
    logic [3:0]       os_next;
    logic [26:0]      ret_addr;

    logic wr_accept;
    logic rd_accept;
    logic wr_last;
    logic rd_last;
    logic rtn;
    logic mismatch;

    logic start_run;
    logic enter_write;
    logic chk_en;
    logic drain_done;

    function automatic logic [31:0] pattern(input logic [26:0] a);
        return {5'b0, a} ^ SEED;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign lpddr2_avl_0_burstcount = 1'b1;

    assign wr_accept   = lpddr2_avl_0_write && lpddr2_avl_0_waitrequest_n;
    assign rd_accept   = lpddr2_avl_0_read  && lpddr2_avl_0_waitrequest_n;
    assign wr_last     = wr_accept && (wr_idx == LAST_IDX);
    assign rd_last     = rd_accept && (rd_idx == LAST_IDX);
    assign wr_idx_inc  = wr_idx + CNT_W'(1);
    assign rd_idx_next = rd_idx + CNT_W'(rd_accept);

    // A return with nothing in flight cannot belong to this run, so it is dropped.
    assign rtn      = chk_en && lpddr2_avl_0_readdatavalid && (outstanding != 4'd0);
    assign mismatch = lpddr2_avl_0_readdata != pattern(ret_addr);
    assign os_next  = outstanding + 4'(rd_accept) - 4'(rtn);

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_WAIT_CAL;
            end
            S_WAIT_CAL: begin
                if (lpddr2_status_local_cal_fail)
                    state_next = S_DONE;
                else if (lpddr2_status_local_init_done && lpddr2_status_local_cal_success)
                    state_next = S_WRITE;
            end
            S_WRITE: begin
                if (wr_last) state_next = S_READ;
            end
            S_READ: begin
                if (rd_last) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == 4'd0) state_next = S_DONE;
            end
            S_DONE: begin
                if (start) state_next = S_WAIT_CAL;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        start_run   = 1'b0;
        enter_write = 1'b0;
        chk_en      = 1'b0;
        drain_done  = 1'b0;
        case (state)
            S_IDLE:     start_run = start;
            S_WAIT_CAL: enter_write = !lpddr2_status_local_cal_fail &&
                                      lpddr2_status_local_init_done &&
                                      lpddr2_status_local_cal_success;
            S_READ:     chk_en = 1'b1;
            S_DRAIN: begin
                chk_en     = 1'b1;
                drain_done = (outstanding == 4'd0);
            end
            S_DONE:     start_run = start;
            default: ;
        endcase
    end

    // Command presentation: a new command is loaded only when none is pending
    // or the pending one is accepted, so stalled commands stay frozen.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lpddr2_avl_0_read               <= 1'b0;
            lpddr2_avl_0_write              <= 1'b0;
            lpddr2_avl_0_beginbursttransfer <= 1'b0;
            lpddr2_avl_0_address            <= 27'd0;
            lpddr2_avl_0_writedata          <= 32'd0;
            lpddr2_avl_0_byteenable         <= 4'd0;
            wr_idx                          <= '0;
            rd_idx                          <= '0;
        end else begin
            lpddr2_avl_0_beginbursttransfer <= 1'b0;
            if (start_run) begin
                lpddr2_avl_0_read       <= 1'b0;
                lpddr2_avl_0_write      <= 1'b0;
                lpddr2_avl_0_byteenable <= 4'd0;
                wr_idx                  <= '0;
                rd_idx                  <= '0;
            end else if (enter_write) begin
                lpddr2_avl_0_write              <= 1'b1;
                lpddr2_avl_0_beginbursttransfer <= 1'b1;
                lpddr2_avl_0_address            <= BASE_ADDR;
                lpddr2_avl_0_writedata          <= pattern(BASE_ADDR);
                lpddr2_avl_0_byteenable         <= 4'hF;
                wr_idx                          <= '0;
            end else if (state == S_WRITE && wr_accept) begin
                lpddr2_avl_0_beginbursttransfer <= 1'b1;
                lpddr2_avl_0_byteenable         <= 4'hF;
                if (wr_last) begin
                    // Nothing is outstanding yet, so the first read goes out at once.
                    lpddr2_avl_0_write     <= 1'b0;
                    lpddr2_avl_0_read      <= 1'b1;
                    lpddr2_avl_0_address   <= BASE_ADDR;
                    lpddr2_avl_0_writedata <= 32'd0;
                    rd_idx                 <= '0;
                end else begin
                    wr_idx                 <= wr_idx_inc;
                    lpddr2_avl_0_address   <= BASE_ADDR + wr_idx_inc[26:0];
                    lpddr2_avl_0_writedata <= pattern(BASE_ADDR + wr_idx_inc[26:0]);
                end
            end else if (state == S_READ) begin
                rd_idx <= rd_idx_next;
                if (!lpddr2_avl_0_read || rd_accept) begin
                    if (rd_idx_next < NUM_W && os_next < MAX_OS) begin
                        lpddr2_avl_0_read               <= 1'b1;
                        lpddr2_avl_0_beginbursttransfer <= 1'b1;
                        lpddr2_avl_0_address            <= BASE_ADDR + rd_idx_next[26:0];
                        lpddr2_avl_0_byteenable         <= 4'hF;
                    end else begin
                        lpddr2_avl_0_read       <= 1'b0;
                        lpddr2_avl_0_byteenable <= 4'd0;
                    end
                end
            end
        end
    end

    // Reads in flight and the in-order return address.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            outstanding <= 4'd0;
            ret_addr    <= 27'd0;
        end else if (start_run) begin
            outstanding <= 4'd0;
            ret_addr    <= BASE_ADDR;
        end else begin
            outstanding <= os_next;
            if (rtn) ret_addr <= ret_addr + 27'd1;
        end
    end

    // Registered status: run flags follow the next state, results follow the checker.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_err_addr <= 27'd0;
        end else begin
            busy <= (state_next == S_WAIT_CAL) || (state_next == S_WRITE) ||
                    (state_next == S_READ)     || (state_next == S_DRAIN);
            done <= (state_next == S_DONE);
            if (start_run) begin
                pass           <= 1'b0;
                err_count      <= 16'd0;
                first_err_addr <= 27'd0;
            end else begin
                if (rtn && mismatch) begin
                    err_count <= sat_inc(err_count);
                    if (err_count == 16'd0) first_err_addr <= ret_addr;
                end
                if (drain_done)
                    pass <= (err_count == 16'd0) && lpddr2_status_local_cal_success;
            end
        end
    end

endmodule

// File: doc/lpddr2_avl_tester.md
Name: lpddr2_avl_tester

Overview:
- Avalon-MM master that drives the LPDDR2 controller's 32-bit local port (lpddr2_avl_0_*).
- Waits for controller init/calibration, writes a deterministic pattern over a word range, reads it back with pipelined reads, and reports pass/fail with error count and first failing address.
- Sits beside the LPDDR2 controller in the top level as a bring-up and self-test engine.

Parameters:
BASE_ADDR, 27'h0, first word address tested (Avalon word address, 32-bit words)
NUM_WORDS, 1024, number of words tested, 1..2^27-BASE_ADDR
SEED, 32'hA5C3_0F96, pattern XOR constant
MAX_OUTSTANDING, 8, maximum reads issued but not yet returned, 1..15

Ports:
clk_clk  in  1  controller user clock; all logic on rising edge
reset_reset_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a test run
busy  out  1  high from accepted start until done
done  out  1  sticky high at end of run; cleared by next accepted start
pass  out  1  valid when done: 1 = zero errors and calibration succeeded
err_count  out  16  mismatching words, saturates at 16'hFFFF
first_err_addr  out  27  address of first mismatch; 0 if none
lpddr2_status_local_init_done  in  1  controller init complete
lpddr2_status_local_cal_success  in  1  calibration passed
lpddr2_status_local_cal_fail  in  1  calibration failed
lpddr2_avl_0_waitrequest_n  in  1  high = slave accepts command this cycle
lpddr2_avl_0_beginbursttransfer  out  1  first-presentation cycle of each command
lpddr2_avl_0_address  out  27  word address
lpddr2_avl_0_readdatavalid  in  1  read data valid
lpddr2_avl_0_readdata  in  32  read data
lpddr2_avl_0_writedata  out  32  write data
lpddr2_avl_0_byteenable  out  4  always 4'hF while a command is presented
lpddr2_avl_0_read  out  1  read command
lpddr2_avl_0_write  out  1  write command
lpddr2_avl_0_burstcount  out  1  constant 1

Behaviour:
- Reset: busy=0, done=0, pass=0, err_count=0, first_err_addr=0, read=0, write=0, beginbursttransfer=0, address=0, writedata=0, byteenable=0; FSM in IDLE; counters zeroed. Reset mid-run abandons the run immediately; pending read returns after reset are ignored.
- Pattern: pattern(a) = {5'b0, a} ^ SEED, where a is the 27-bit word address.
- Command accepted on a cycle where (read|write) && waitrequest_n. While waitrequest_n=0, address, writedata, byteenable and read/write are held stable. beginbursttransfer is high only on the first cycle a given command is presented. read and write are never both high.
- FSM states:
  - IDLE: start -> WAIT_CAL; clear done, pass, err_count, first_err_addr; busy=1. start is ignored in any state other than IDLE or DONE.
  - WAIT_CAL: if cal_fail=1 -> DONE with pass=0, no commands issued. If init_done && cal_success -> WRITE.
  - WRITE: present writes at BASE_ADDR+i, i=0..NUM_WORDS-1, one per accepted cycle, back-to-back when waitrequest_n=1. After the last write is accepted -> READ.
  - READ: present reads at BASE_ADDR+j. Issue only while outstanding < MAX_OUTSTANDING, where outstanding = issued - returned, updated same cycle. On acceptance and return in the same cycle, outstanding is unchanged. After the last read is accepted -> DRAIN.
  - DRAIN: wait until outstanding == 0 -> DONE.
  - DONE: done=1, busy=0. pass = (err_count==0) && cal_success. start -> WAIT_CAL, same clearing as IDLE.
- Read check: returns are in order. A return-address counter starting at BASE_ADDR increments on each readdatavalid. Mismatch when readdata != pattern(return address). On mismatch: err_count+1 (saturating). If err_count was 0, capture first_err_addr.
- readdatavalid in IDLE, WAIT_CAL, WRITE or DONE is ignored.
- Status outputs are registered and update the cycle after the causing event.

Test Plan:
- Zero-wait memory model, NUM_WORDS=16, BASE_ADDR=0x100 -> 16 writes at 0x100..0x10F with data pattern(a), then 16 reads; done=1, pass=1, err_count=0; total run ≤ 40 cycles after cal_success.
- Random waitrequest_n low 50% of cycles -> address, data and command stable while stalled; beginbursttransfer exactly once per command; write count 16, read count 16.
- Model corrupts word at 0x105 (bit 0 flipped) and 0x10A -> err_count=2, first_err_addr=0x105, pass=0.
- cal_fail=1 after start -> done=1, pass=0, zero read/write cycles observed.
- Fixed read latency 20 cycles, MAX_OUTSTANDING=8 -> outstanding never exceeds 8; read issue stalls at 8; all 16 checked; pass=1.
- reset_reset_n pulsed low mid-WRITE at i=7 -> all outputs reset values on the same edge; new start runs a full 16-word test with pass=1.
